bist_session_ctrl: RTL and testbench

BIST_SESSION_CTRL -- requirements
Module: bist_session_ctrl

---
 rtl/bist_pkg.sv | 22 ++
 rtl/bist_cfg_table.sv | 52 +++++
 rtl/bist_session_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bist_session_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST session controller.
// Holds the FSM encoding and seed/timeout constants.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam int SRSG_SEED_DEF = 5;
  localparam int SISR_SEED_DEF = 24;
  localparam int TIMEOUT_DEF   = 4096;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_cfg_table.sv
// Configuration table: per-entry SRSG/SISR polynomials and golden signature.
// Synchronous write, combinational read, cleared by reset.
module bist_cfg_table
  import bist_pkg::*;
#(
  parameter int NUM_CFG = 4,
  parameter int SW      = 16,
  parameter int QW      = 16,
  parameter int IW      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_addr,
  input  logic [SW-1:0] i_srsg,
  input  logic [QW-1:0] i_sisr,
  input  logic [QW-1:0] i_gold,
  input  logic [IW-1:0] i_rd_addr,
  output logic [SW-1:0] o_srsg,
  output logic [QW-1:0] o_sisr,
  output logic [QW-1:0] o_gold
);

  logic [SW-1:0] r_srsg [NUM_CFG];
  logic [QW-1:0] r_sisr [NUM_CFG];
  logic [QW-1:0] r_gold [NUM_CFG];

  logic w_wrOk;
  logic w_rdOk;

  assign w_wrOk = i_wr_en && (int'(i_wr_addr) < NUM_CFG);
  assign w_rdOk = int'(i_rd_addr) < NUM_CFG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        r_srsg[k] <= '0;
        r_sisr[k] <= '0;
        r_gold[k] <= '0;
      end
    end else if (w_wrOk) begin
      r_srsg[i_wr_addr] <= i_srsg;
      r_sisr[i_wr_addr] <= i_sisr;
      r_gold[i_wr_addr] <= i_gold;
    end
  end

  assign o_srsg = w_rdOk ? r_srsg[i_rd_addr] : '0;
  assign o_sisr = w_rdOk ? r_sisr[i_rd_addr] : '0;
  assign o_gold = w_rdOk ? r_gold[i_rd_addr] : '0;

endmodule

// File: rtl/bist_session_ctrl.sv
// BIST session controller: walks the config table, kicks the monitor,
// waits for its done edge or a timeout, and compares against golden.
module bist_session_ctrl
  import bist_pkg::*;
#(
  parameter int SRSG_Size    = 16,
  parameter int SISR_Size    = 16,
  parameter int NUM_CFG      = 4,
  parameter int SRSG_SeedVal = SRSG_SEED_DEF,
  parameter int SISR_SeedVal = SISR_SEED_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          masterRstN,
  input  logic                          start,
  input  logic [$clog2(NUM_CFG):0]      numCfg,
  input  logic                          cfgWrEn,
  input  logic [idx_w(NUM_CFG)-1:0]     cfgWrAddr,
  input  logic [SRSG_Size-1:0]          srsgPolyIn,
  input  logic [SISR_Size-1:0]          sisrPolyIn,
  input  logic [SISR_Size-1:0]          goldenIn,
  input  logic                          monDone,
  input  logic [SISR_Size-1:0]          SISR_Out,
  output logic                          monRst,
  output logic [SRSG_Size-1:0]          SRSG_Seed,
  output logic [SRSG_Size-1:0]          SRSG_Poly,
  output logic [SISR_Size-1:0]          SISR_Seed,
  output logic [SISR_Size-1:0]          SISR_Poly,
  output logic [idx_w(NUM_CFG)-1:0]     cfgIdx,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [NUM_CFG-1:0]            failMap,
  output logic                          timeoutErr
);

  localparam int IW = idx_w(NUM_CFG);
  localparam int CW = $clog2(NUM_CFG) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_runCnt;
  logic [IW-1:0]        r_idx;
  logic [SRSG_Size-1:0] r_srsgPoly;
  logic [SISR_Size-1:0] r_sisrPoly;
  logic [TW-1:0]        r_tmo;
  logic                 r_monPrev;
  logic                 r_skip;
  logic [NUM_CFG-1:0]   r_failMap;
  logic                 r_pass;
  logic                 r_done;
  logic                 r_tmoErr;

  logic                 w_wrEn;
  logic [SRSG_Size-1:0] w_tSrsg;
  logic [SISR_Size-1:0] w_tSisr;
  logic [SISR_Size-1:0] w_tGold;
  logic                 w_rise;
  logic                 w_tmoHit;
  logic                 w_last;
  logic                 w_mismatch;
  logic [CW-1:0]        w_runLat;

  assign w_wrEn = cfgWrEn && (r_state == S_IDLE);

  bist_cfg_table #(
    .NUM_CFG (NUM_CFG),
    .SW      (SRSG_Size),
    .QW      (SISR_Size),
    .IW      (IW)
  ) u_table (
    .clk       (clk),
    .rst_n     (masterRstN),
    .i_wr_en   (w_wrEn),
    .i_wr_addr (cfgWrAddr),
    .i_srsg    (srsgPolyIn),
    .i_sisr    (sisrPolyIn),
    .i_gold    (goldenIn),
    .i_rd_addr (r_idx),
    .o_srsg    (w_tSrsg),
    .o_sisr    (w_tSisr),
    .o_gold    (w_tGold)
  );

  assign w_rise     = monDone && !r_monPrev;
  assign w_tmoHit   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_last     = (CW'(r_idx) + CW'(1)) == r_runCnt;
  assign w_mismatch = (SISR_Out != w_tGold);
  assign w_runLat   = (numCfg > CW'(NUM_CFG)) ? CW'(NUM_CFG) : numCfg;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (w_runLat == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD:  w_next = S_KICK;
      S_KICK:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_rise || w_tmoHit) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK:  w_next = w_last ? S_FINISH : S_LOAD;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge masterRstN) begin
    if (!masterRstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge masterRstN) begin
    if (!masterRstN) begin
      r_runCnt   <= '0;
      r_idx      <= '0;
      r_srsgPoly <= '0;
      r_sisrPoly <= '0;
      r_tmo      <= '0;
      r_monPrev  <= 1'b0;
      r_skip     <= 1'b0;
      r_failMap  <= '0;
      r_pass     <= 1'b0;
      r_done     <= 1'b0;
      r_tmoErr   <= 1'b0;
    end else begin
      r_monPrev <= monDone;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_runCnt  <= w_runLat;
            r_idx     <= '0;
            r_failMap <= '0;
            r_pass    <= 1'b0;
            r_tmoErr  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_srsgPoly <= w_tSrsg;
          r_sisrPoly <= w_tSisr;
        end
        S_KICK: begin
          r_tmo  <= '0;
          r_skip <= 1'b0;
        end
        S_WAIT: begin
          if (!w_rise) begin
            if (w_tmoHit) begin
              r_failMap[r_idx] <= 1'b1;
              r_tmoErr         <= 1'b1;
              r_skip           <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        S_CHECK: begin
          if (!r_skip && w_mismatch) begin
            r_failMap[r_idx] <= 1'b1;
          end
          if (!w_last) begin
            r_idx <= r_idx + IW'(1);
          end
        end
        // done and pass become visible together, the cycle after FINISH
        S_FINISH: begin
          r_done <= 1'b1;
          r_pass <= (r_failMap == '0);
        end
        default: ;
      endcase
    end
  end

  assign monRst     = (r_state == S_KICK);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign failMap    = r_failMap;
  assign timeoutErr = r_tmoErr;
  assign cfgIdx     = r_idx;
  assign SRSG_Poly  = r_srsgPoly;
  assign SISR_Poly  = r_sisrPoly;
  assign SRSG_Seed  = SRSG_Size'(SRSG_SeedVal);
  assign SISR_Seed  = SISR_Size'(SISR_SeedVal);

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Scoreboard bench for bist_session_ctrl with a behavioural monitor mock.
// Responder emulates the OnChipMonitor; checker pops expectations on outputs.
module tb_bist_session_ctrl;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        masterRstN = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  numCfg = '0;
  logic        cfgWrEn = 1'b0;
  logic [1:0]  cfgWrAddr = '0;
  logic [15:0] srsgPolyIn = '0;
  logic [15:0] sisrPolyIn = '0;
  logic [15:0] goldenIn = '0;
  logic        monDone = 1'b0;
  logic [15:0] SISR_Out = '0;
  logic        monRst;
  logic [15:0] SRSG_Seed;
  logic [15:0] SRSG_Poly;
  logic [15:0] SISR_Seed;
  logic [15:0] SISR_Poly;
  logic [1:0]  cfgIdx;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  failMap;
  logic        timeoutErr;

  bist_session_ctrl #(
    .SRSG_Size (16), .SISR_Size (16), .NUM_CFG (N),
    .SRSG_SeedVal (5), .SISR_SeedVal (24), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .masterRstN (masterRstN), .start (start),
    .numCfg (numCfg), .cfgWrEn (cfgWrEn), .cfgWrAddr (cfgWrAddr),
    .srsgPolyIn (srsgPolyIn), .sisrPolyIn (sisrPolyIn),
    .goldenIn (goldenIn), .monDone (monDone), .SISR_Out (SISR_Out),
    .monRst (monRst), .SRSG_Seed (SRSG_Seed), .SRSG_Poly (SRSG_Poly),
    .SISR_Seed (SISR_Seed), .SISR_Poly (SISR_Poly), .cfgIdx (cfgIdx),
    .busy (busy), .done (done), .pass (pass), .failMap (failMap),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] fm;
    logic       ok;
    logic       terr;
  } res_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_srsg [N];
  logic [15:0] m_sisr [N];
  logic [15:0] m_gold [N];
  int   q_idx [$];
  int   q_plan [$];
  res_t q_res [$];
  int kick_cyc = 0, done_cyc = 0, rise_cyc = 0;
  int n_kicks = 0, n_dones = 0;
  bit rise_pending = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sig(input logic [15:0] s,
                                      input logic [15:0] i);
    return (s * 16'd3) ^ {i[7:0], i[15:8]} ^ 16'h5a5a;
  endfunction

  // Monitor mock. Plan: >0 respond after that many cycles,
  // -1 hold done low forever, -2 leave a stale high done untouched.
  initial forever begin
    @(negedge clk);
    if (monRst) begin
      int p;
      p = (q_plan.size() > 0) ? q_plan.pop_front() : -1;
      if (p != -2) begin
        @(posedge clk); #1 monDone = 1'b0;
        if (p > 0) begin
          repeat (p) @(posedge clk);
          #1;
          SISR_Out     = sig(SRSG_Poly, SISR_Poly);
          monDone      = 1'b1;
          rise_cyc     = cyc;
          rise_pending = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (masterRstN && monRst) begin
      n_kicks++;
      kick_cyc = cyc;
      if (q_idx.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_kick actual=1 required=0 t=%0t", $time);
      end else begin
        chk("kick_cfgIdx", cfgIdx, q_idx.pop_front());
      end
      if (rise_pending) begin
        chk("rise_to_kick", kick_cyc - rise_cyc, 3);
        rise_pending = 0;
      end
    end
    if (masterRstN && done) begin
      n_dones++;
      done_cyc = cyc;
      rise_pending = 0;
      if (q_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end else begin
        res_t r;
        r = q_res.pop_front();
        chk("failMap", failMap, r.fm);
        chk("pass", pass, r.ok);
        chk("timeoutErr", timeoutErr, r.terr);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [15:0] s, input logic [15:0] i,
                    input logic [15:0] g, input bit upd);
    tick();
    cfgWrEn = 1'b1; cfgWrAddr = a[1:0];
    srsgPolyIn = s; sisrPolyIn = i; goldenIn = g;
    tick();
    cfgWrEn = 1'b0;
    if (upd) begin
      m_srsg[a] = s; m_sisr[a] = i; m_gold[a] = g;
    end
  endtask

  task automatic wr_cfg(input int a, input bit bad);
    logic [15:0] s, i, g;
    s = 16'($urandom); i = 16'($urandom);
    g = sig(s, i);
    if (bad) g = g ^ 16'(1 << $urandom_range(0, 15));
    wr(a, s, i, g, 1);
  endtask

  task automatic session(input int n, input int plan [4]);
    int runs, st, k0, d0, w;
    logic [3:0] fm;
    bit terr;
    runs = (n > N) ? N : n;
    fm = '0; terr = 0;
    for (int k = 0; k < runs; k++) begin
      q_idx.push_back(k);
      q_plan.push_back(plan[k]);
      if (plan[k] < 0) begin
        fm[k] = 1'b1; terr = 1;
      end else if (m_gold[k] != sig(m_srsg[k], m_sisr[k])) begin
        fm[k] = 1'b1;
      end
    end
    q_res.push_back('{fm, (fm == '0), terr});
    k0 = n_kicks; d0 = n_dones;
    tick();
    numCfg = n[2:0]; start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0; numCfg = 3'($urandom);
    chk("busy_run", busy, 1);
    w = 0;
    while (n_dones == d0 && w < 3000) begin
      tick(); w++;
    end
    if (n_dones == d0) begin
      checks++; errors++;
      $display("FAIL done_wait actual=none required=done t=%0t", $time);
      q_res.delete();
    end
    chk("kick_count", n_kicks - k0, runs);
    chk("cfgIdx_hold", cfgIdx, (runs > 0) ? runs - 1 : 0);
    chk("failMap_hold", failMap, fm);
    if (runs == 0) chk("start_to_done", done_cyc - st, 2);
    if (runs == 1) chk("start_to_kick", kick_cyc - st, 2);
    if (runs == 1 && plan[0] == -1) chk("kick_to_done_tmo", done_cyc - kick_cyc, TMO + 3);
    if (runs == 1 && plan[0] > 0) chk("kick_to_done", done_cyc - kick_cyc, plan[0] + 4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int pl [4];
    int w, k0;
    for (int k = 0; k < N; k++) begin
      m_srsg[k] = '0; m_sisr[k] = '0; m_gold[k] = '0;
    end
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_monRst", monRst, 0);
    chk("rst_pass", pass, 0);
    chk("rst_failMap", failMap, 0);
    chk("rst_timeoutErr", timeoutErr, 0);
    chk("rst_cfgIdx", cfgIdx, 0);
    chk("rst_SRSG_Poly", SRSG_Poly, 0);
    chk("rst_SISR_Poly", SISR_Poly, 0);
    chk("SRSG_Seed", SRSG_Seed, 5);
    chk("SISR_Seed", SISR_Seed, 24);
    tick(); masterRstN = 1'b1; tick();

    wr(0, 16'h8016, 16'h8016, sig(16'h8016, 16'h8016), 1);
    session(1, '{3, 1, 1, 1});
    chk("poly_srsg", SRSG_Poly, 16'h8016);
    chk("poly_sisr", SISR_Poly, 16'h8016);

    for (int k = 0; k < N; k++) wr_cfg(k, k == 2);
    for (int k = 0; k < N; k++) pl[k] = $urandom_range(1, 12);
    session(4, pl);

    session(1, '{-1, 1, 1, 1});
    session(1, '{2, 1, 1, 1});
    session(1, '{-2, 1, 1, 1});

    session(0, '{1, 1, 1, 1});
    for (int k = 0; k < N; k++) pl[k] = $urandom_range(1, 12);
    session(7, pl);
    session(5, '{4, -1, 2, 6});

    fork
      session(1, '{12, 1, 1, 1});
      begin
        repeat (3) tick();
        chk("wr_while_busy", busy, 1);
        wr(0, m_srsg[0], m_sisr[0], ~m_gold[0], 0);
      end
    join
    session(1, '{2, 1, 1, 1});

    for (int it = 0; it < 8; it++) begin
      wr_cfg($urandom_range(0, N - 1), $urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++)
        pl[k] = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 10);
      session($urandom_range(0, 7), pl);
    end

    for (int k = 0; k < N; k++) wr_cfg(k, 0);
    q_idx.push_back(0); q_idx.push_back(1);
    q_plan.push_back(3); q_plan.push_back(-1);
    k0 = n_kicks;
    tick(); numCfg = 3'd4; start = 1'b1;
    tick(); start = 1'b0;
    w = 0;
    while (n_kicks < k0 + 2 && w < 500) begin
      tick(); w++;
    end
    chk("abort_reached_cfg1", cfgIdx, 1);
    repeat (5) tick();
    masterRstN = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_failMap", failMap, 0);
    chk("abort_cfgIdx", cfgIdx, 0);
    chk("abort_SRSG_Poly", SRSG_Poly, 0);
    q_idx.delete(); q_plan.delete();
    for (int k = 0; k < N; k++) begin
      m_srsg[k] = '0; m_sisr[k] = '0; m_gold[k] = '0;
    end
    repeat (3) tick();
    masterRstN = 1'b1;
    repeat (10) tick();
    chk("abort_no_done", n_dones, n_dones);
    session(1, '{2, 1, 1, 1});
    wr_cfg(0, 0); wr_cfg(1, 0);
    session(2, '{2, 3, 1, 1});

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
